uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter with byte FIFO, 8N1 framing, optional even parity.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          ser_q, ser_d;
  logic          done_q, done_d;
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   count_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          push, pop, last, not_empty;

  assign o_tx_ready  = (count_q < DEPTH);
  assign o_tx_serial = ser_q;
  assign o_tx_done   = done_q;
  assign o_tx_active = (state_q != IDLE);

  assign push      = i_tx_dv & o_tx_ready & i_reset_n;
  assign last      = (cnt_q == CNT_MAX);
  assign not_empty = (count_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    ser_d   = 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (not_empty) begin
          pop     = 1'b1;
          data_d  = mem[rd_q];
          state_d = START;
        end
      end
      START: begin
        ser_d = 1'b0;
        if (last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        ser_d = data_q[bit_q];
        if (last) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        ser_d = ^data_q;
        if (last) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (last) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // Back-to-back frames: go straight to START with no idle cycle
          if (not_empty) begin
            pop     = 1'b1;
            data_d  = mem[rd_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      if (push && !pop)      count_q <= count_q + (PW+1)'(1);
      else if (pop && !push) count_q <= count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) mem[wr_q] <= i_tx_byte;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: table of single-byte frames plus
// sequences for back-to-back, FIFO full, and mid-frame reset.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready, ser, active, done;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_tx_dv    (dv),
    .i_tx_byte  (din),
    .o_tx_ready (ready),
    .o_tx_serial(ser),
    .o_tx_active(active),
    .o_tx_done  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [10:0] q_frm[$];
  int          q_st[$];
  int          q_dn[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: captures each frame sampled at the first cycle of every bit
  logic [10:0] m_f;
  int          m_st;
  bit          m_ab;
  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && ser === 1'b0) begin
      m_f  = '0;
      m_st = cyc;
      m_ab = 1'b0;
      for (int b = 1; b < NB; b++) begin
        for (int j = 0; j < CPB; j++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) m_ab = 1'b1;
        end
        m_f[b] = ser;
      end
      if (!m_ab) begin
        q_frm.push_back(m_f);
        q_st.push_back(m_st);
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) q_dn.push_back(cyc);

  task automatic flush();
    q_frm.delete();
    q_st.delete();
    q_dn.delete();
  endtask

  task automatic wr(input logic [7:0] b, output int wc);
    @(negedge clk);
    dv  = 1'b1;
    din = b;
    @(negedge clk);
    dv = 1'b0;
    wc = cyc;
  endtask

  task automatic wait_frames(input int n, input int lim, input string name);
    int t;
    t = 0;
    while (q_frm.size() < n && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(q_frm.size() >= n), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frm;
    logic       par;
  } vec_t;

  vec_t        tv[8];
  int          wc, tc;
  logic [10:0] exp_f;
  logic [7:0]  six[6];
  logic        rdy[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{8'h55, 10'h2AA, 1'b0};
    tv[1] = '{8'h00, 10'h200, 1'b0};
    tv[2] = '{8'hFF, 10'h3FE, 1'b0};
    tv[3] = '{8'h81, 10'h302, 1'b0};
    tv[4] = '{8'h07, 10'h20E, 1'b1};
    tv[5] = '{8'h03, 10'h206, 1'b0};
    tv[6] = '{8'h80, 10'h300, 1'b1};
    tv[7] = '{8'hA5, 10'h34A, 1'b0};
    six   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset with a write presented during reset
    rst_n = 1'b0;
    dv    = 1'b1;
    din   = 8'h99;
    repeat (3) @(negedge clk);
    chk("rst_serial", ser, 1);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    dv    = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    repeat (FL + 10) @(negedge clk);
    chk("rst_write_ignored", q_frm.size(), 0);

    // Table of single frames
    for (int i = 0; i < 8; i++) begin
      flush();
      wr(tv[i].data, wc);
`ifdef UART_TX_PARITY_EN
      exp_f = {1'b1, tv[i].par, tv[i].frm[8:0]};
`else
      exp_f = {1'b0, tv[i].frm};
`endif
      wait_frames(1, FL + 20, "frame_rx");
      repeat (8) @(negedge clk);
      if (q_frm.size() > 0) begin
        chk("frame_bits", q_frm[0], exp_f);
        chk("latency", q_st[0] - wc, 2);
      end
      if (q_dn.size() > 0 && q_st.size() > 0)
        chk("done_offset", q_dn[0] - q_st[0], FL - 1);
      chk("done_count", q_dn.size(), 1);
      chk("idle_active", active, 0);
    end

    // Two bytes on consecutive cycles: no idle gap
    flush();
    @(negedge clk);
    dv  = 1'b1;
    din = 8'hA5;
    @(negedge clk);
    din = 8'h3C;
    @(negedge clk);
    dv = 1'b0;
    wait_frames(2, 2 * FL + 20, "b2b_rx");
    repeat (8) @(negedge clk);
    if (q_frm.size() > 1) begin
      chk("b2b_byte0", q_frm[0][8:1], 8'hA5);
      chk("b2b_byte1", q_frm[1][8:1], 8'h3C);
      chk("b2b_gap", q_st[1] - q_st[0], FL);
    end
    chk("b2b_done_count", q_dn.size(), 2);
    if (q_dn.size() > 1)
      chk("b2b_done_gap", q_dn[1] - q_dn[0], FL);

    // Six back-to-back writes: sixth dropped
    flush();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdy[i] = ready;
      dv     = 1'b1;
      din    = six[i];
    end
    @(negedge clk);
    dv = 1'b0;
    for (int i = 0; i < 6; i++)
      chk("six_ready", rdy[i], (i == 5) ? 1'b0 : 1'b1);
    wait_frames(5, 5 * FL + 20, "six_rx");
    repeat (FL + 20) @(negedge clk);
    chk("six_frame_count", q_frm.size(), 5);
    for (int i = 0; i < 5; i++)
      if (q_frm.size() > i) chk("six_byte", q_frm[i][8:1], six[i]);

    // Full FIFO: write coinciding with pop is dropped
    flush();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dv  = 1'b1;
      din = six[i];
    end
    @(negedge clk);
    chk("full_ready", ready, 0);
    din = 8'hEE;
    tc  = 0;
    while (ready !== 1'b1 && tc < 2 * FL) begin
      @(negedge clk);
      tc++;
    end
    dv = 1'b0;
    tc = cyc;
    chk("pop_ready", ready, 1);
    if (q_st.size() > 0) chk("pop_cycle", tc - q_st[0], FL - 1);
    wait_frames(5, 5 * FL + 20, "full_rx");
    repeat (FL + 20) @(negedge clk);
    chk("full_frame_count", q_frm.size(), 5);
    for (int i = 0; i < 5; i++)
      if (q_frm.size() > i) chk("full_byte", q_frm[i][8:1], six[i]);

    // Reset during data bit 3 with two bytes queued
    flush();
    @(negedge clk);
    dv  = 1'b1;
    din = 8'h0F;
    @(negedge clk);
    din = 8'hF0;
    @(negedge clk);
    din = 8'h5A;
    @(negedge clk);
    dv = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_rst_active", active, 1);
    rst_n = 1'b0;
    dv    = 1'b1;
    din   = 8'h77;
    @(negedge clk);
    chk("mid_rst_serial", ser, 1);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_done", done, 0);
    rst_n = 1'b1;
    dv    = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", ready, 1);
    repeat (3 * FL + 20) @(negedge clk);
    chk("mid_rst_frames", q_frm.size(), 0);
    chk("mid_rst_dones", q_dn.size(), 0);
    chk("mid_rst_idle", active, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
